gpi_irq: RTL and testbench
==========================

# gpi_irq

Parametrised general-purpose input block with interrupt support, sitting on the system memory bus beside the other `sys/gpio` peripherals. Samples N asynchronous pins through a synchroniser chain and an optional per-pin debounce filter, and exposes the filtered level. Latches enabled rising/falling edges into a sticky write-1-to-clear pending register and drives a single level interrupt to the core.

## Interface
- `N`, 32: number of input pins, 1..32; register bits at or above N read 0 and ignore writes.
- `SYNC_STAGES`, 2: synchroniser flops per pin, minimum 2.
- `DB_WIDTH`, 16: width of the DEBOUNCE register and of each per-pin counter.
- `BASE`, `GPI_BASE` from `memmap.svh`: base of the 32-byte register window.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `gpi_data` in N: raw asynchronous pins.
- `i_rd` in 1: read strobe.
- `i_addr` in 32: byte address.
- `i_wr` in 1: write strobe.
- `i_wrmask` in 4: byte enables for `i_data`.
- `i_data` in 32: write data.
- `o_rd_valid` out 1: read acknowledge.
- `o_wr_valid` out 1: write acknowledge.
- `o_data` out 32: read data, 0 when not acknowledging.
- `o_irq` out 1: interrupt; OR of all PENDING bits.

## Operation
- Register map, offsets from BASE, 32-bit word access only:
  - 0x00 LEVEL: read-only filtered level. Writes are acknowledged and ignored.
  - 0x04 RISE_EN: read/write rising-edge enables.
  - 0x08 FALL_EN: read/write falling-edge enables.
  - 0x0C PENDING: read returns pending bits; writing 1 clears a bit, writing 0 leaves it.
  - 0x10 DEBOUNCE: read/write, low DB_WIDTH bits; upper bits read 0.
- Address decode:
  - Address in window and matching a defined offset: `o_rd_valid` = `i_rd`, `o_wr_valid` = `i_wr`.
  - Any other address (undefined offset or outside the window): both valid outputs 0 and `o_data` = 0.
- Byte enables: `i_wrmask[k]` gates byte k of every writable register. A disabled byte of PENDING clears nothing.
- Synchroniser: `sync[i]` is `gpi_data[i]` delayed through SYNC_STAGES flops.
- Debounce, per pin, holding filtered bit `filt[i]` and counter `cnt[i]`:
  - If `sync == filt`: `cnt` <= 0.
  - Otherwise, if `cnt >= DEBOUNCE`: `filt` <= `sync` and `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt + 1`.
  - Effect: `cnt` never exceeds DEBOUNCE, so it cannot wrap. DEBOUNCE = 0 means `filt` follows `sync` one cycle later.
  - A glitch shorter than DEBOUNCE+1 cycles never reaches `filt`.
  - Changing DEBOUNCE mid-count takes effect on the next compare.
- Edge events: `rise[i]` is 1 in the cycle `filt[i]` is being updated 0->1; `fall[i]` likewise for 1->0.
- PENDING next value = (PENDING & ~clear) | (rise & RISE_EN) | (fall & FALL_EN). Set wins over a same-cycle clear.
- Clearing an enable does not clear an already-pending bit.
- `o_irq` = |PENDING, driven directly from flops.

## Timing
- Reset (`rst_n` low, asynchronous): all synchroniser flops, `filt`, `cnt`, RISE_EN, FALL_EN, PENDING and DEBOUNCE go to 0, and `o_irq` = 0.
  - Bus outputs are combinational and follow the decode above.
  - A pin held high through reset produces a rise after release, but the enables are 0, so no pending bit is set.
- Bus: reads are combinational, with `o_rd_valid`/`o_data` valid in the same cycle as `i_rd`. Writes commit on the next `clk` rising edge and are acknowledged in the strobe cycle.
- A read of a register in the same cycle as a write to it returns the old value.
- Pin-to-LEVEL latency, with the pin stable before edge 0: `sync` updates at edge SYNC_STAGES-1; `filt`, the PENDING bit and `o_irq` update at edge SYNC_STAGES+DEBOUNCE.
  - Defaults (SYNC_STAGES = 2, DEBOUNCE = 0): 3 edges.
- A W1C write clears PENDING at its commit edge, and `o_irq` falls that same edge if no other bit is pending.
- Reset asserted mid-count or with PENDING set discards all state immediately.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C/0x10 -> all 0; read 0x14 -> `o_rd_valid` 0, `o_data` 0; `o_irq` 0.
- DEBOUNCE=0, RISE_EN=0x1, pin0 0->1 -> LEVEL bit0 = 1 and PENDING = 0x1 exactly 3 edges after the change, `o_irq` 1; with FALL_EN=0, pin0 back to 0 -> PENDING unchanged.
- DEBOUNCE=4: a 4-cycle high pulse on pin3 -> LEVEL unchanged and no pending; a 5-cycle pulse -> LEVEL bit3 rises 7 edges after the pin.
- PENDING=0x3: write 0x1 to 0x0C with `i_wrmask`=0xF -> PENDING=0x2, `o_irq` stays 1; write 0x2 with `i_wrmask`=0x0 -> no change; write 0x2 with mask 0x1 -> `o_irq` 0.
- W1C of bit5 in the same cycle as a new enabled rise on pin5 -> PENDING bit5 remains 1.
- N=8: write 0xFFFFFFFF to RISE_EN -> read back 0x000000FF; `rst_n` low mid-debounce -> every register reads 0 next cycle.

Source files
------------

// File: rtl/gpi_irq.sv
// General-purpose input block: synchronised, debounced pins with a filtered level
// view and edge-triggered sticky interrupts behind a 32-byte register window.
`ifndef GPI_BASE
`define GPI_BASE 32'h2000_0000
`endif

module gpi_irq #(
  parameter int          N           = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          DB_WIDTH    = 16,
  parameter logic [31:0] BASE        = `GPI_BASE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gpi_data,
  input  logic         i_rd,
  input  logic [31:0]  i_addr,
  input  logic         i_wr,
  input  logic [3:0]   i_wrmask,
  input  logic [31:0]  i_data,
  output logic         o_rd_valid,
  output logic         o_wr_valid,
  output logic [31:0]  o_data,
  output logic         o_irq
);

  logic [SYNC_STAGES-1:0][N-1:0] sync_reg;
  logic [N-1:0]                  sync_bits;
  logic [N-1:0]                  filt_reg;
  logic [DB_WIDTH-1:0]           cnt_reg [N];
  logic [N-1:0]                  upd;
  logic [N-1:0]                  rise;
  logic [N-1:0]                  fall;

  logic [N-1:0]          rise_en_reg, rise_en_next;
  logic [N-1:0]          fall_en_reg, fall_en_next;
  logic [N-1:0]          pending_reg, pending_next;
  logic [DB_WIDTH-1:0]   debounce_reg, debounce_next;
  logic                  irq_reg;
  logic [N-1:0]          pend_clr;

  logic [31:0] bmask;
  logic        in_win;
  logic [4:0]  off;
  logic        sel_level, sel_rise, sel_fall, sel_pend, sel_db, hit;
  logic [31:0] rdata;

  // Synchroniser shift chain; the last stage feeds the debounce filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpi_data};
  end

  assign sync_bits = sync_reg[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pin
      assign upd[gi]  = (sync_bits[gi] != filt_reg[gi]) && (cnt_reg[gi] >= debounce_reg);
      assign rise[gi] = upd[gi] &  sync_bits[gi];
      assign fall[gi] = upd[gi] & ~sync_bits[gi];

      // Counter only runs while the input disagrees with the filtered level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          filt_reg[gi] <= 1'b0;
          cnt_reg[gi]  <= '0;
        end else if (sync_bits[gi] == filt_reg[gi]) begin
          cnt_reg[gi]  <= '0;
        end else if (upd[gi]) begin
          filt_reg[gi] <= sync_bits[gi];
          cnt_reg[gi]  <= '0;
        end else begin
          cnt_reg[gi]  <= cnt_reg[gi] + 1'b1;
        end
      end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_bmask
      assign bmask[8*gi +: 8] = {8{i_wrmask[gi]}};
    end
  endgenerate

  // Word-aligned offsets inside the window only.
  assign in_win    = (i_addr[31:5] == BASE[31:5]);
  assign off       = i_addr[4:0];
  assign sel_level = in_win && (off == 5'h00);
  assign sel_rise  = in_win && (off == 5'h04);
  assign sel_fall  = in_win && (off == 5'h08);
  assign sel_pend  = in_win && (off == 5'h0C);
  assign sel_db    = in_win && (off == 5'h10);
  assign hit       = sel_level | sel_rise | sel_fall | sel_pend | sel_db;

  always_comb begin
    rise_en_next  = rise_en_reg;
    fall_en_next  = fall_en_reg;
    debounce_next = debounce_reg;
    pend_clr      = '0;
    if (i_wr && sel_rise)
      rise_en_next = (rise_en_reg & ~bmask[N-1:0]) | (i_data[N-1:0] & bmask[N-1:0]);
    if (i_wr && sel_fall)
      fall_en_next = (fall_en_reg & ~bmask[N-1:0]) | (i_data[N-1:0] & bmask[N-1:0]);
    if (i_wr && sel_db)
      debounce_next = (debounce_reg & ~bmask[DB_WIDTH-1:0])
                    | (i_data[DB_WIDTH-1:0] & bmask[DB_WIDTH-1:0]);
    if (i_wr && sel_pend)
      pend_clr = i_data[N-1:0] & bmask[N-1:0];
    // New events are OR-ed in after the clear so a same-cycle set wins.
    pending_next = (pending_reg & ~pend_clr) | (rise & rise_en_reg) | (fall & fall_en_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      pending_reg  <= '0;
      debounce_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      rise_en_reg  <= rise_en_next;
      fall_en_reg  <= fall_en_next;
      pending_reg  <= pending_next;
      debounce_reg <= debounce_next;
      irq_reg      <= |pending_next;
    end
  end

  assign o_irq = irq_reg;

  always_comb begin
    rdata = '0;
    if (sel_level)     rdata[N-1:0]        = filt_reg;
    else if (sel_rise) rdata[N-1:0]        = rise_en_reg;
    else if (sel_fall) rdata[N-1:0]        = fall_en_reg;
    else if (sel_pend) rdata[N-1:0]        = pending_reg;
    else if (sel_db)   rdata[DB_WIDTH-1:0] = debounce_reg;
  end

  assign o_rd_valid = i_rd & hit;
  assign o_wr_valid = i_wr & hit;
  assign o_data     = (i_rd && hit) ? rdata : 32'h0;

endmodule

// File: tb/tb_gpi_irq.sv
// Directed bench for gpi_irq (N=8): bus reads are scored against expected values
// queued when each read is issued.
module tb_gpi_irq;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [31:0] A_LEVEL = BASE + 32'h00;
  localparam logic [31:0] A_RISE  = BASE + 32'h04;
  localparam logic [31:0] A_FALL  = BASE + 32'h08;
  localparam logic [31:0] A_PEND  = BASE + 32'h0C;
  localparam logic [31:0] A_DB    = BASE + 32'h10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] gpi_data;
  logic         i_rd, i_wr;
  logic [31:0]  i_addr, i_data;
  logic [3:0]   i_wrmask;
  logic         o_rd_valid, o_wr_valid, o_irq;
  logic [31:0]  o_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_vld_q[$];
  string       tag_q[$];

  gpi_irq #(.N(N), .SYNC_STAGES(2), .DB_WIDTH(16), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .gpi_data(gpi_data),
    .i_rd(i_rd), .i_addr(i_addr), .i_wr(i_wr), .i_wrmask(i_wrmask), .i_data(i_data),
    .o_rd_valid(o_rd_valid), .o_wr_valid(o_wr_valid), .o_data(o_data), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read, sampled 1 time unit after driving, consumes no edge.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                    input logic exp_v = 1'b1);
    logic [31:0] e;
    logic        v;
    string       t;
    exp_data_q.push_back(exp);
    exp_vld_q.push_back(exp_v);
    tag_q.push_back(tag);
    i_rd   = 1'b1;
    i_addr = addr;
    #1;
    e = exp_data_q.pop_front();
    v = exp_vld_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".vld"}, {31'b0, o_rd_valid}, {31'b0, v});
    check(t, o_data, e);
    $display("rd  %h -> %h (vld %0d) [%s]", addr, o_data, o_rd_valid, t);
    i_rd = 1'b0;
  endtask

  // Write commits on the next rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                    input logic exp_v = 1'b1);
    i_wr     = 1'b1;
    i_addr   = addr;
    i_data   = data;
    i_wrmask = mask;
    #1;
    check($sformatf("wr_vld@%h", addr), {31'b0, o_wr_valid}, {31'b0, exp_v});
    $display("wr  %h <- %h mask %h", addr, data, mask);
    tick();
    i_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; gpi_data = '0; i_rd = 1'b0; i_wr = 1'b0;
    i_addr = '0; i_data = '0; i_wrmask = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and decode
    rd(A_LEVEL, 0, "rst_level");
    rd(A_RISE,  0, "rst_rise");
    rd(A_FALL,  0, "rst_fall");
    rd(A_PEND,  0, "rst_pend");
    rd(A_DB,    0, "rst_db");
    rd(BASE + 32'h14, 0, "undef_off", 1'b0);
    rd(BASE + 32'h40, 0, "out_win", 1'b0);
    rd(BASE + 32'h05, 0, "misalign", 1'b0);
    check("rst_irq", {31'b0, o_irq}, 0);
    wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b0);

    // Enables, read-only LEVEL
    wr(A_RISE, 32'h0000_002B, 4'hF);
    rd(A_RISE, 32'h2B, "rise_en_rb");
    wr(A_LEVEL, 32'hFF, 4'hF);
    rd(A_LEVEL, 0, "level_ro");

    // Pin0 rise, DEBOUNCE=0: visible exactly at edge 2
    gpi_data[0] = 1'b1;
    tick();
    rd(A_LEVEL, 0, "p0_e0");
    tick();
    rd(A_LEVEL, 0, "p0_e1");
    check("p0_e1_irq", {31'b0, o_irq}, 0);
    tick();
    rd(A_LEVEL, 32'h1, "p0_e2");
    rd(A_PEND,  32'h1, "p0_pend");
    check("p0_irq", {31'b0, o_irq}, 1);

    // Fall with FALL_EN=0 leaves PENDING alone
    gpi_data[0] = 1'b0;
    repeat (4) tick();
    rd(A_LEVEL, 0, "p0_fall_level");
    rd(A_PEND, 32'h1, "p0_fall_pend");

    wr(A_PEND, 32'hFF, 4'hF);
    rd(A_PEND, 0, "clr_all");
    check("clr_irq", {31'b0, o_irq}, 0);

    // Debounce 4: 4-cycle pulse rejected, 5-cycle pulse accepted at edge 6
    wr(A_DB, 32'h4, 4'hF);
    rd(A_DB, 32'h4, "db_rb");
    gpi_data[3] = 1'b1;
    repeat (4) tick();
    gpi_data[3] = 1'b0;
    repeat (8) tick();
    rd(A_LEVEL, 0, "glitch_level");
    rd(A_PEND,  0, "glitch_pend");

    gpi_data[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 4) gpi_data[3] = 1'b0;
    end
    rd(A_LEVEL, 0, "p3_e5");
    tick();
    rd(A_LEVEL, 32'h08, "p3_e6");
    rd(A_PEND,  32'h08, "p3_pend");
    check("p3_irq", {31'b0, o_irq}, 1);
    repeat (10) tick();
    rd(A_LEVEL, 0, "p3_fall");
    rd(A_PEND, 32'h08, "p3_fall_pend");

    // W1C with byte enables
    wr(A_DB, 32'h0, 4'hF);
    wr(A_PEND, 32'hFF, 4'hF);
    gpi_data[1:0] = 2'b11;
    repeat (4) tick();
    rd(A_PEND, 32'h3, "pend3");
    wr(A_PEND, 32'h1, 4'hF);
    rd(A_PEND, 32'h2, "w1c_bit0");
    check("w1c_irq_hold", {31'b0, o_irq}, 1);
    wr(A_PEND, 32'h2, 4'h0);
    rd(A_PEND, 32'h2, "w1c_mask0");
    wr(A_PEND, 32'h2, 4'h1);
    rd(A_PEND, 0, "w1c_bit1");
    check("w1c_irq_fall", {31'b0, o_irq}, 0);

    // Same-cycle set and clear on pin5: set wins
    gpi_data[5] = 1'b1;
    tick();
    tick();
    wr(A_PEND, 32'h20, 4'hF);
    rd(A_PEND, 32'h20, "set_wins");
    check("set_wins_irq", {31'b0, o_irq}, 1);

    // Bits above N and partial byte writes
    wr(A_RISE, 32'hFFFF_FFFF, 4'hF);
    rd(A_RISE, 32'hFF, "rise_n8");
    wr(A_FALL, 32'hC0, 4'h2);
    rd(A_FALL, 0, "fall_mask2");
    wr(A_FALL, 32'hC0, 4'h1);
    rd(A_FALL, 32'hC0, "fall_mask1");
    wr(A_DB, 32'hFFFF_1234, 4'hF);
    rd(A_DB, 32'h1234, "db_upper");

    // Reset mid-debounce with PENDING set
    wr(A_DB, 32'h8, 4'hF);
    gpi_data[7] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_irq", {31'b0, o_irq}, 0);
    tick();
    rd(A_LEVEL, 0, "rr_level");
    rd(A_RISE,  0, "rr_rise");
    rd(A_FALL,  0, "rr_fall");
    rd(A_PEND,  0, "rr_pend");
    rd(A_DB,    0, "rr_db");
    rst_n = 1'b1;
    repeat (5) tick();
    rd(A_LEVEL, 32'hA3, "post_rst_level");
    rd(A_PEND,  0, "post_rst_pend");
    check("post_rst_irq", {31'b0, o_irq}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
